// File: rtl/sound_card.sv
// Self-contained music player: a note sequencer drives three square-wave tone
// channels which are summed into one signed 8-bit sample per clock.

module music_storage #(
    parameter int unsigned MEM_DEPTH = 1024,
    parameter int unsigned AW        = 10
) (
    input  logic [AW-1:0] addr,
    output logic [31:0]   note
);
    // Preloaded note table; no write port, contents are loaded from outside.
    reg [31:0] mem [0:MEM_DEPTH-1];

    assign note = mem[addr];
endmodule

module sequencer #(
    parameter int unsigned MEM_DEPTH   = 1024,
    parameter int unsigned BEAT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] note,
    output logic        advance_c,
    output logic        halted_c
);
    localparam int unsigned AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int unsigned BW = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;
    localparam logic [31:0] END_WORD = 32'h1100_0000;

    logic [AW-1:0] addr;
    logic [BW-1:0] beat_cnt;
    logic [7:0]    dur_cnt;
    logic [7:0]    dur_eff;
    logic          beat_last;

    music_storage #(.MEM_DEPTH(MEM_DEPTH), .AW(AW)) music_storage (
        .addr (addr),
        .note (note)
    );

    // A zero duration plays for one beat; the end marker freezes everything.
    always_comb begin
        dur_eff   = (note[31:24] == 8'd0) ? 8'd1 : note[31:24];
        halted_c  = (note == END_WORD);
        beat_last = (beat_cnt == BW'(BEAT_CYCLES - 1));
        advance_c = !halted_c && beat_last && (dur_cnt == dur_eff - 8'd1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr     <= '0;
            beat_cnt <= '0;
            dur_cnt  <= '0;
        end else if (!halted_c) begin
            if (beat_last) begin
                beat_cnt <= '0;
                if (advance_c) begin
                    dur_cnt <= '0;
                    addr    <= (addr == AW'(MEM_DEPTH - 1)) ? '0 : addr + AW'(1);
                end else begin
                    dur_cnt <= dur_cnt + 8'd1;
                end
            end else begin
                beat_cnt <= beat_cnt + BW'(1);
            end
        end
    end
endmodule

module tone_channel #(
    parameter int unsigned TONE_SCALE = 4,
    parameter int unsigned AMP        = 40
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [7:0]         pitch,
    input  logic               restart,
    output logic signed [9:0]  level_c
);
    localparam int unsigned CW = $clog2(255 * TONE_SCALE + 1);
    localparam logic signed [9:0] AMP_L = 10'(AMP);

    logic [CW-1:0] cnt;
    logic [CW-1:0] half_m1;
    logic          phase;

    always_comb begin
        half_m1 = CW'(pitch) * CW'(TONE_SCALE) - CW'(1);
        level_c = '0;
        if (pitch != 8'd0) begin
            level_c = phase ? AMP_L : -AMP_L;
        end
    end

    // Half-period counter; silent channels and note changes restart the waveform.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (restart || pitch == 8'd0) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (cnt == half_m1) begin
            cnt   <= '0;
            phase <= ~phase;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end
endmodule

module sound_card #(
    parameter int unsigned MEM_DEPTH   = 1024,
    parameter int unsigned BEAT_CYCLES = 256,
    parameter int unsigned TONE_SCALE  = 4,
    parameter int unsigned AMP         = 40
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic signed [7:0] combined
);
    logic [31:0]       note;
    logic              advance_c;
    logic              halted_c;
    logic signed [9:0] levels [3];
    logic signed [9:0] mix_c;

    sequencer #(.MEM_DEPTH(MEM_DEPTH), .BEAT_CYCLES(BEAT_CYCLES)) in_ctrls (
        .clk       (clk),
        .rst_n     (rst_n),
        .note      (note),
        .advance_c (advance_c),
        .halted_c  (halted_c)
    );

    for (genvar c = 0; c < 3; c++) begin : gen_ch
        tone_channel #(.TONE_SCALE(TONE_SCALE), .AMP(AMP)) u_ch (
            .clk     (clk),
            .rst_n   (rst_n),
            .pitch   (halted_c ? 8'd0 : note[8*c +: 8]),
            .restart (advance_c),
            .level_c (levels[c])
        );
    end

    // Sum at 10 bits; 3*AMP fits in 8 bits so truncation is lossless.
    always_comb begin
        mix_c = levels[0] + levels[1] + levels[2];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            combined <= '0;
        end else begin
            combined <= mix_c[7:0];
        end
    end
endmodule

// File: tb/tb_sound_card.sv
// Scoreboard bench for sound_card: a time-since-note-start model predicts every
// sample, note and address; a second small-memory instance exercises wrap-around.
`timescale 1ns/1ps

module tb_sound_card;
    localparam int unsigned BEAT = 256;
    localparam int unsigned TS   = 4;
    localparam int          AMP  = 40;
    localparam logic [31:0] END_WORD = 32'h1100_0000;

    typedef struct {
        logic [7:0]  comb;
        logic [31:0] note;
        int unsigned addr;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic signed [7:0] combined;
    logic signed [7:0] combined_w;

    sound_card #(.MEM_DEPTH(1024)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .combined (combined)
    );

    sound_card #(.MEM_DEPTH(4)) dut_w (
        .clk      (clk),
        .rst_n    (rst_n),
        .combined (combined_w)
    );

    always #5 clk = ~clk;

    int          tests  = 0;
    int          errors = 0;
    logic [31:0] mm [2][16];
    int unsigned ma [2];
    int unsigned mt [2];
    int unsigned depth [2];
    exp_t        q0 [$];
    exp_t        q1 [$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    // Expected sample comes from the note state before the edge; note/addr from after it.
    function automatic exp_t model_step(input int i);
        exp_t        e;
        logic [31:0] w;
        int          sum;
        int unsigned p;
        int unsigned dur;
        w   = mm[i][ma[i]];
        sum = 0;
        if (w != END_WORD) begin
            for (int c = 0; c < 3; c++) begin
                p = 32'(w[8*c +: 8]);
                if (p != 0) sum += (((mt[i] / (p * TS)) % 2) == 1) ? AMP : -AMP;
            end
            dur = (w[31:24] == 8'd0) ? 1 : 32'(w[31:24]);
            mt[i]++;
            if (mt[i] == dur * BEAT) begin
                mt[i] = 0;
                ma[i] = (ma[i] + 1) % depth[i];
            end
        end
        e.comb = 8'(sum);
        e.note = mm[i][ma[i]];
        e.addr = ma[i];
        return e;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                ma[i] = 0;
                mt[i] = 0;
            end
            q0.delete();
            q1.delete();
        end else begin
            q0.push_back(model_step(0));
            q1.push_back(model_step(1));
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && q0.size() > 0) begin
            e = q0.pop_front();
            check_eq("combined", 32'($unsigned(combined)), 32'(e.comb));
            check_eq("note", dut.in_ctrls.music_storage.note, e.note);
            check_eq("addr", 32'(dut.in_ctrls.addr), e.addr);
        end
        if (rst_n && q1.size() > 0) begin
            e = q1.pop_front();
            check_eq("wrap_combined", 32'($unsigned(combined_w)), 32'(e.comb));
            check_eq("wrap_addr", 32'(dut_w.in_ctrls.addr), e.addr);
        end
    end

    task automatic load_main(input logic [31:0] w0, input logic [31:0] w1,
                             input logic [31:0] w2, input logic [31:0] w3);
        logic [31:0] ws [4];
        ws[0] = w0; ws[1] = w1; ws[2] = w2; ws[3] = w3;
        for (int k = 0; k < 16; k++) begin
            mm[0][k] = (k < 4) ? ws[k] : END_WORD;
            dut.in_ctrls.music_storage.mem[k] = mm[0][k];
        end
    endtask

    task automatic play(input logic [31:0] w0, input logic [31:0] w1,
                        input logic [31:0] w2, input logic [31:0] w3, input int cycles);
        rst_n = 1'b0;
        load_main(w0, w1, w2, w3);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (cycles) @(posedge clk);
    endtask

    initial begin
        depth[0] = 1024;
        depth[1] = 4;
        for (int k = 0; k < 16; k++) mm[1][k] = 32'h0100_0000 | 32'(k % 4 + 1);
        for (int k = 0; k < 4; k++) dut_w.in_ctrls.music_storage.mem[k] = mm[1][k];

        // Reset state before any clocking.
        #1;
        check_eq("reset_combined", 32'($unsigned(combined)), 32'h0);
        check_eq("reset_addr", 32'(dut.in_ctrls.addr), 32'h0);

        // Single tone, chord, silence with zero duration.
        play(32'h0100_0005, END_WORD, END_WORD, END_WORD, 300);
        play(32'h0205_0302, END_WORD, END_WORD, END_WORD, 560);
        play(32'h0000_0000, END_WORD, END_WORD, END_WORD, 300);

        // Durations 1,3,2 then marker; wrap instance runs through its table too.
        play(32'h0100_0005, 32'h0300_0203, 32'h0200_0004, END_WORD, 1600);

        // Asynchronous reset in the middle of the second note.
        play(32'h0100_0005, 32'h0300_0203, 32'h0200_0004, END_WORD, 400);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("midreset_combined", 32'($unsigned(combined)), 32'h0);
        check_eq("midreset_addr", 32'(dut.in_ctrls.addr), 32'h0);
        check_eq("midreset_note", dut.in_ctrls.music_storage.note, mm[0][0]);
        check_eq("midreset_wrap_combined", 32'($unsigned(combined_w)), 32'h0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (300) @(posedge clk);

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end
endmodule

// File: doc/sound_card.md
Name: sound_card

Overview:
- Self-contained music player.
- Steps through a preloaded table of 32-bit note words, one word per note event.
- Drives three square-wave tone channels from each word and mixes them into one signed 8-bit sample per clock on `combined`.
- Top level of the sound path; its output feeds the DAC/sample-dump stage.

Parameters:
- MEM_DEPTH, 1024, number of 32-bit words in the note memory; address width is clog2(MEM_DEPTH).
- BEAT_CYCLES, 256, clock cycles per duration unit.
- TONE_SCALE, 4, clock cycles per pitch unit; a channel's half-period = pitch*TONE_SCALE.
- AMP, 40, signed level of one active channel (±AMP); must satisfy 3*AMP <= 127.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- combined  output  8  signed two's-complement mixed sample, registered.

Behaviour:
- Hierarchy (required for bench preload and end detection):
  - Sequencer instance named in_ctrls, containing storage instance music_storage.
  - music_storage holds `reg [31:0] mem [0:MEM_DEPTH-1]`, loadable by $readmemh; no write port.
  - music_storage exposes `note` (32 bits) = mem[addr], combinational read.
- Note word format:
  - [31:24] duration in beats; 0 is treated as 1.
  - [23:16] ch2 pitch; [15:8] ch1 pitch; [7:0] ch0 pitch.
  - Pitch 0 = channel silent.
- End marker: note == 32'h11000000 halts the sequencer.
  - addr frozen, so note stays at the marker value.
  - All channels silent; combined = 0 from the next cycle, held until reset.
- Reset (async assert, sync release):
  - addr = 0, beat counter = 0, duration counter = 0.
  - All channel phase counters = 0, all phase bits = 0.
  - combined = 0.
- Sequencing:
  - After reset, word 0 plays for max(dur,1)*BEAT_CYCLES clocks.
  - On the last cycle of that window addr increments; the new word takes effect the following cycle.
  - Counters restart at 0 on every note change.
  - addr wraps from MEM_DEPTH-1 to 0 if no marker is encountered.
- Tone channel n, when its pitch p != 0:
  - Phase counter counts 0..p*TONE_SCALE-1; on reaching the terminal value it resets to 0 and toggles the phase bit.
  - Level = +AMP when phase = 1, -AMP when phase = 0.
  - First toggle happens p*TONE_SCALE cycles after the note starts.
- Channel with pitch 0: level 0, phase counter and phase bit held at 0.
- Pitch change at a note boundary: phase counter and phase bit restart at 0.
- Mix:
  - combined <= ch0 + ch1 + ch2, computed at 10-bit signed width then truncated to 8 bits.
  - No overflow is possible given the AMP constraint.
  - One clock latency from channel levels to combined.
- Uninitialised (X) memory is not a supported input; the bench always preloads memory, ending with a marker.

Test Plan:
- Reset: assert rst_n=0 mid-note -> combined=0, addr=0, note=mem[0] immediately; after release, word 0 replays from its start.
- Single tone: mem[0]=32'h01000005, mem[1]=32'h11000000, defaults -> combined alternates -40 / +40 with half-period 20 clocks for 256 clocks. Then note==32'h11000000 and combined=0 thereafter.
- Chord: mem[0]=32'h02050302 (ch0 p=2, ch1 p=3, ch2 p=5) -> combined takes only values in {-120,-40,+40,+120}. Value is -120 during the first 8 cycles after the note starts, and the pattern repeats every lcm(16,24,40)=240 clocks, for 512 clocks.
- Duration-zero and silence: mem[0]=32'h00000000, mem[1]=32'h11000000 -> combined=0 for exactly 256 cycles, then marker reached.
- Sequencing across words: words with durations 1,3,2 then marker -> note changes after 256, 768 and 512 cycles respectively; marker observed at cycle 1536 after reset release.
- Wrap: MEM_DEPTH=4, no marker, all durations 1 -> addr sequence 0,1,2,3,0 with a change every 256 cycles.
